// File: rtl/uniform_poly_sampler.sv
// ---------------------------------------------------------------------------
// uniform_poly_sampler
//   Turns 64-bit pseudo-random words from the free-running LFSR into N
//   coefficients uniformly distributed in [0,Q) by rejection sampling. Each
//   word is split into CHUNKS = 64/COEF_W chunks, taken LSB first. A chunk is
//   kept only if it is below Q. Kept chunks leave on a valid/ready stream
//   tagged with their coefficient index. One start produces one polynomial.
//
// Ports
//   clk         in   1       clock
//   s_rst_n     in   1       asynchronous active-low reset
//   start       in   1       begin one polynomial (honoured only when idle)
//   rnd_in      in   64      LFSR word, sampled only in the LOAD cycle
//   coef_data   out  COEF_W  accepted coefficient (< Q)
//   coef_idx    out  IDX_W   index 0..N-1 of coef_data
//   coef_valid  out  1       coef_data / coef_idx valid
//   coef_ready  in   1       downstream accepts
//   busy        out  1       high while loading or emitting
//   done        out  1       one-cycle pulse after coefficient N-1 handshakes
//   rej_cnt     out  16      rejected chunks this polynomial (saturating)
// ---------------------------------------------------------------------------
module uniform_poly_sampler #(
  parameter int COEF_W = 16,
  parameter int Q      = 12289,
  parameter int N      = 1024,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [63:0]       rnd_in,
  output logic [COEF_W-1:0] coef_data,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rej_cnt
);

  localparam int                CHUNKS   = 64 / COEF_W;
  localparam int                PTR_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [COEF_W-1:0] Q_C      = COEF_W'(Q);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(CHUNKS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [63:0]       r_buf;
  logic [PTR_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  logic [15:0]       r_rej;

  logic [COEF_W-1:0] w_cand;
  logic              w_emit;
  logic              w_below_q;
  logic              w_hs;
  logic              w_reject;
  logic              w_last_chunk;

  // Chunk currently under test, selected by r_ptr.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    w_cand = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (r_ptr == PTR_W'(c)) w_cand = r_buf[c*COEF_W +: COEF_W];
    end
  end

  // Unsigned full-width compare: cand == Q is rejected, cand == Q-1 kept.
  assign w_emit       = (r_state == S_EMIT);
  assign w_below_q    = (w_cand < Q_C);
  assign w_hs         = w_emit && w_below_q && coef_ready;
  assign w_reject     = w_emit && !w_below_q;
  assign w_last_chunk = (r_ptr == LAST_PTR);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. Completing the last coefficient wins over refilling.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = S_EMIT;
      S_EMIT: begin
        if (w_hs && (r_idx == LAST_IDX))            w_next = S_DONE;
        else if ((w_hs || w_reject) && w_last_chunk) w_next = S_LOAD;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: word buffer, chunk pointer, coefficient index, reject counter.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_buf <= '0;
      r_ptr <= '0;
      r_idx <= '0;
      r_rej <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            r_ptr <= '0;
            r_rej <= '0;
          end
        end
        S_LOAD: begin
          r_buf <= rnd_in;
          r_ptr <= '0;
        end
        S_EMIT: begin
          if (w_hs || w_reject) r_ptr <= w_last_chunk ? '0 : r_ptr + PTR_W'(1);
          if (w_hs)             r_idx <= r_idx + IDX_W'(1);
          if (w_reject && (r_rej != 16'hFFFF)) r_rej <= r_rej + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, never on coef_ready.
  always_comb begin
    busy       = (r_state == S_LOAD) || (r_state == S_EMIT);
    done       = (r_state == S_DONE);
    coef_valid = w_emit && w_below_q;
    coef_data  = w_cand;
    coef_idx   = r_idx;
    rej_cnt    = r_rej;
  end

endmodule

// File: tb/tb_uniform_poly_sampler.sv
// ---------------------------------------------------------------------------
// tb_uniform_poly_sampler
//   Directed bench for uniform_poly_sampler with N=4, Q=12289, COEF_W=16.
//   The reference walks the supplied words chunk by chunk and schedules the
//   expected per-cycle outputs; a single compare process checks them.
// ---------------------------------------------------------------------------
module tb_uniform_poly_sampler;

  localparam int COEF_W = 16;
  localparam int Q      = 12289;
  localparam int N      = 4;
  localparam int IDX_W  = $clog2(N);

  logic              clk = 1'b0;
  logic              s_rst_n;
  logic              start;
  logic [63:0]       rnd_in;
  logic [COEF_W-1:0] coef_data;
  logic [IDX_W-1:0]  coef_idx;
  logic              coef_valid;
  logic              coef_ready;
  logic              busy;
  logic              done;
  logic [15:0]       rej_cnt;

  uniform_poly_sampler #(.COEF_W(COEF_W), .Q(Q), .N(N)) dut (
    .clk        (clk),
    .s_rst_n    (s_rst_n),
    .start      (start),
    .rnd_in     (rnd_in),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done),
    .rej_cnt    (rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } hs_t;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  bit          e_valid, e_busy, e_done;
  int          e_data, e_idx, e_rej;

  // Reference-model inputs and state.
  logic [63:0] words[$];
  int          stall_idx     = -1;
  int          stall_len     = 0;
  bit          poke_start    = 1'b0;
  int          stop_after_hs = -1;
  int          exp_rej       = 0;

  hs_t         hs_log[$];
  int          done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One cycle: drive inputs and record what the outputs must be this cycle.
  task automatic step(input bit v, input int d, input int ix, input bit b,
                      input bit dn, input bit rdy, input logic [63:0] rnd,
                      input bit st);
    @(negedge clk);
    start      = st;
    coef_ready = rdy;
    rnd_in     = rnd;
    e_valid    = v;
    e_data     = d;
    e_idx      = ix;
    e_busy     = b;
    e_done     = dn;
    e_rej      = exp_rej;
    chk_en     = 1'b1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 1, rnd64(), 0);
  endtask

  // Reference: start, then per word one LOAD cycle followed by one cycle per
  // rejected chunk and one or more cycles per kept chunk, stopping at the
  // N-th handshake (then a done cycle), after stop_after_hs handshakes, or
  // when the word list runs out.
  task automatic run_poly();
    int          hs;
    logic [63:0] wd;
    int          ch;
    hs = 0;
    step(0, 0, 0, 0, 0, 1, rnd64(), 1);
    exp_rej = 0;
    foreach (words[w]) begin
      wd = words[w];
      step(0, 0, 0, 1, 0, 1, wd, poke_start);
      for (int c = 0; c < 64 / COEF_W; c++) begin
        ch = int'(wd[c*COEF_W +: COEF_W]);
        if (ch >= Q) begin
          step(0, 0, 0, 1, 0, 1, rnd64(), poke_start);
          if (exp_rej < 65535) exp_rej++;
        end else begin
          if (hs == stall_idx) begin
            repeat (stall_len) step(1, ch, hs, 1, 0, 0, rnd64(), poke_start);
          end
          step(1, ch, hs, 1, 0, 1, rnd64(), poke_start);
          hs++;
          if (hs == N) begin
            step(0, 0, 0, 0, 1, 1, rnd64(), poke_start);
            return;
          end
          if (hs == stop_after_hs) return;
        end
      end
    end
  endtask

  task automatic stop_checking();
    @(posedge clk);
    #3;
    chk_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(coef_valid), 0);
    check({tag, "_busy"},  int'(busy),       0);
    check({tag, "_done"},  int'(done),       0);
    check({tag, "_rej"},   int'(rej_cnt),    0);
    check({tag, "_data"},  int'(coef_data),  0);
    check({tag, "_idx"},   int'(coef_idx),   0);
  endtask

  // Compare process: checks every cycle while a schedule is active and logs
  // handshakes/done pulses for the literal checks.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("valid", int'(coef_valid), int'(e_valid));
      check("busy",  int'(busy),       int'(e_busy));
      check("done",  int'(done),       int'(e_done));
      check("rej",   int'(rej_cnt),    e_rej);
      if (e_valid) begin
        check("data", int'(coef_data), e_data);
        check("idx",  int'(coef_idx),  e_idx);
      end
    end
    if (coef_valid && coef_ready) hs_log.push_back('{int'(coef_idx), int'(coef_data)});
    if (done) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    s_rst_n    = 1'b0;
    start      = 1'b0;
    coef_ready = 1'b0;
    rnd_in     = '0;

    // Reset state.
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    idle_step();

    // Basic word: chunks 0001, 3000, FFFF(reject), 0005; second word finishes.
    words = '{64'h0005_FFFF_3000_0001, 64'h0000_0000_0000_0009};
    hs_log.delete();
    run_poly();
    idle_step();
    stop_checking();
    check("basic_n",   hs_log.size(), 4);
    check("basic_d0",  hs_log[0].data, 1);
    check("basic_d1",  hs_log[1].data, 12288);
    check("basic_d2",  hs_log[2].data, 5);
    check("basic_i2",  hs_log[2].idx,  2);
    check("basic_d3",  hs_log[3].data, 9);
    check("basic_rej", int'(rej_cnt),  1);

    // Q boundary: 0x3000 kept, 0x3001 rejected; leftover chunks discarded.
    words = '{64'h0002_0001_3001_3000, 64'h3001_3001_3001_0004};
    hs_log.delete();
    run_poly();
    idle_step();
    stop_checking();
    check("qb_d0",  hs_log[0].data, 12288);
    check("qb_d1",  hs_log[1].data, 1);
    check("qb_d3",  hs_log[3].data, 4);
    check("qb_rej", int'(rej_cnt),  1);

    // Backpressure: idx 1 held for 5 cycles while rnd_in keeps changing.
    words = '{64'h0004_0003_0002_0001};
    stall_idx = 1;
    stall_len = 5;
    hs_log.delete();
    run_poly();
    idle_step();
    stop_checking();
    stall_idx = -1;
    stall_len = 0;
    check("bp_n",  hs_log.size(), 4);
    check("bp_i1", hs_log[1].idx,  1);
    check("bp_d1", hs_log[1].data, 2);
    check("bp_i2", hs_log[2].idx,  2);

    // Completion with start held high while busy and in the done cycle.
    words = '{64'h0007_0007_0007_0007, 64'h0007_0007_0007_0007};
    poke_start = 1'b1;
    hs_log.delete();
    d0 = done_seen;
    run_poly();
    poke_start = 1'b0;
    idle_step();
    idle_step();
    stop_checking();
    check("cmp_n",    hs_log.size(), 4);
    check("cmp_i3",   hs_log[3].idx, 3);
    check("cmp_done", done_seen - d0, 1);

    // All-reject: three all-ones words, 12 rejections, no valid.
    words = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    hs_log.delete();
    run_poly();
    step(0, 0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    stop_checking();
    check("rej_cnt12", int'(rej_cnt),  12);
    check("rej_nohs",  hs_log.size(), 0);
    s_rst_n = 1'b0;
    #1;
    check_all_zero("rst_a");
    @(negedge clk);
    s_rst_n = 1'b1;
    exp_rej = 0;

    // Reset mid-run after idx 2 handshakes, then a fresh run from idx 0.
    words = '{64'h0004_0003_0002_0001};
    stop_after_hs = 3;
    hs_log.delete();
    run_poly();
    stop_checking();
    d0 = done_seen;
    check("mid_valid", int'(coef_valid), 1);
    s_rst_n = 1'b0;
    #1;
    check_all_zero("rst_b");
    repeat (3) @(negedge clk);
    check("mid_nodone", done_seen - d0, 0);
    s_rst_n = 1'b1;
    exp_rej = 0;
    stop_after_hs = -1;
    words = '{64'h000A_000B_000C_000D};
    hs_log.delete();
    run_poly();
    idle_step();
    stop_checking();
    check("rs_i0", hs_log[0].idx,  0);
    check("rs_d0", hs_log[0].data, 13);
    check("rs_d3", hs_log[3].data, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
